// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
//   Shared definitions for the CIC decimator / interpolator pair.
//   - clog2()       : ceiling log2 usable in constant expressions.
//   - cic_growth()  : net bit growth of an N-stage CIC with differential delay M
//                     and rate change 2^log2_r, after the 1/R rate division
//                     inherent to interpolation.
//   - cic_step_e    : classification of one enabled clock cycle.
//   - CIC_WIDTH_CHECK macro: elaboration-time guard that the accumulator
//                     width can hold the full growth of the input.
// -----------------------------------------------------------------------------
`ifndef CIC_PKG_SV
`define CIC_PKG_SV

// Elaboration-time guard; expands to a generate-if, so it may only be used
// at module-item level.
`define CIC_WIDTH_CHECK(prec, xw, growth) \
  if ((prec) < (xw) + (growth)) begin : g_width_check \
    $error("cic: PRECISION=%0d is narrower than X_WIDTH=%0d + GROWTH=%0d", \
           (prec), (xw), (growth)); \
  end

package cic_pkg;

  localparam int CIC_MAX_STAGES = 6;
  localparam int CIC_MAX_LOG2_R = 6;
  localparam int CIC_MAX_M      = 2;

  // What the datapath does in a given cycle.
  typedef enum logic [1:0] {
    STEP_NONE   = 2'd0,  // frozen: disabled, or starved at phase 0
    STEP_STUFF  = 2'd1,  // high-rate step with a stuffed zero
    STEP_ACCEPT = 2'd2   // high-rate step that also consumes a new sample
  } cic_step_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Net DC gain of the interpolator is (R*M)^N / R = 2^growth.
  function automatic int cic_growth(input int n, input int m, input int log2_r);
    return n * (log2_r + clog2(m)) - log2_r;
  endfunction

endpackage

`endif

// File: rtl/cic_integrator_stage.sv
// -----------------------------------------------------------------------------
// cic_integrator_stage
//   One running-sum stage of a CIC integrator chain. The accumulator wraps
//   modulo 2^PRECISION; the CIC structure guarantees the final result is
//   correct despite intermediate wrap-around.
//
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active-high, clears the accumulator
//   step  : advance enable; accumulator is frozen when low
//   din   : value added on each step (previous stage output or comb output)
//   acc   : registered accumulator value
// -----------------------------------------------------------------------------
module cic_integrator_stage
  import cic_pkg::*;
#(
  parameter int PRECISION = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  input  logic [PRECISION-1:0] din,
  output logic [PRECISION-1:0] acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (step) begin
      acc <= acc + din;
    end
  end

endmodule

// File: rtl/cic_interpolator.sv
// -----------------------------------------------------------------------------
// cic_interpolator
//   N-stage CIC interpolator, rate change R = 2^LOG2_R, differential delay M.
//   Comb chain runs at the input rate, its output is zero-stuffed into the
//   high-rate integrator chain, and the last integrator is shifted right by
//   the net growth to give unity DC gain. The result is MSB-aligned to the
//   output width (LSB truncation or zero padding, never saturation).
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active-high, clears all state
//   enabled  : advance permission; low freezes every register
//   x        : input sample, two's complement, X_WIDTH bits
//   x_valid  : x is presented this cycle
//   x_ready  : block accepts x this cycle (enabled and phase 0)
//   y        : output sample, two's complement, Y_WIDTH bits
//   y_valid  : one-cycle strobe, y was updated by the previous step
// -----------------------------------------------------------------------------
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int N         = 3,
  parameter int M         = 1,
  parameter int LOG2_R    = 2,
  parameter int X_WIDTH   = 16,
  parameter int Y_WIDTH   = 12,
  parameter int PRECISION = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enabled,
  input  logic [X_WIDTH-1:0] x,
  input  logic               x_valid,
  output logic               x_ready,
  output logic [Y_WIDTH-1:0] y,
  output logic               y_valid
);

  localparam int GROWTH   = cic_growth(N, M, LOG2_R);
  localparam int OUT_BITS = (X_WIDTH < Y_WIDTH) ? X_WIDTH : Y_WIDTH;

  // ---------------------------------------------------------------------------
  // Elaboration checks
  // ---------------------------------------------------------------------------
  `CIC_WIDTH_CHECK(PRECISION, X_WIDTH, GROWTH)

  if (N < 1 || N > CIC_MAX_STAGES) begin : g_bad_n
    $error("cic_interpolator: N=%0d outside 1..%0d", N, CIC_MAX_STAGES);
  end
  if (M < 1 || M > CIC_MAX_M) begin : g_bad_m
    $error("cic_interpolator: M=%0d outside 1..%0d", M, CIC_MAX_M);
  end
  if (LOG2_R < 1 || LOG2_R > CIC_MAX_LOG2_R) begin : g_bad_r
    $error("cic_interpolator: LOG2_R=%0d outside 1..%0d", LOG2_R, CIC_MAX_LOG2_R);
  end

  // ---------------------------------------------------------------------------
  // Phase counter and step classification
  // ---------------------------------------------------------------------------
  logic [LOG2_R-1:0] ph;
  cic_step_e         step_kind;
  logic              step;
  logic              accept;

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    step_kind = STEP_NONE;
    if (enabled) begin
      if (ph != '0) begin
        step_kind = STEP_STUFF;
      end else if (x_valid) begin
        step_kind = STEP_ACCEPT;
      end
    end
  end

  assign step    = (step_kind != STEP_NONE);
  assign accept  = (step_kind == STEP_ACCEPT);
  assign x_ready = enabled && (ph == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  // The counter is exactly LOG2_R bits wide, so R-1 -> 0 wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= '0;
    end else if (step) begin
      ph <= ph + LOG2_R'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Comb chain (input rate). Combinational difference against an M-deep delay
  // line per stage; delay lines advance on acceptance steps only.
  // ---------------------------------------------------------------------------
  logic [PRECISION-1:0] x_ext;
  logic [PRECISION-1:0] comb_out;

  assign x_ext = PRECISION'($signed(x));

  for (genvar k = 0; k < N; k++) begin : g_comb
    logic [PRECISION-1:0] din;
    logic [PRECISION-1:0] diff;
    logic [PRECISION-1:0] dly [M];

    if (k == 0) begin : g_first
      assign din = x_ext;
    end else begin : g_rest
      assign din = g_comb[k-1].diff;
    end

    assign diff = din - dly[M-1];

    // NOTE: the delay-line array is reset along with the rest of the state;
    // it is only M words deep and an uncleared history would leak garbage
    // into the first outputs after reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j < M; j++) begin
          dly[j] <= '0;
        end
      end else if (accept) begin
        dly[0] <= din;
        for (int j = 1; j < M; j++) begin
          dly[j] <= dly[j-1];
        end
      end
    end
  end

  assign comb_out = g_comb[N-1].diff;

  // Registered comb output; zero-stuffed on high-rate steps between samples.
  logic [PRECISION-1:0] cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cout <= '0;
    end else if (accept) begin
      cout <= comb_out;
    end else if (step) begin
      cout <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Integrator chain (output rate). Each stage adds the registered output of
  // the previous one, so a sample needs N steps to traverse the chain.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N; k++) begin : g_integ
    logic [PRECISION-1:0] din;
    logic [PRECISION-1:0] acc;

    if (k == 0) begin : g_first
      assign din = cout;
    end else begin : g_rest
      assign din = g_integ[k-1].acc;
    end

    cic_integrator_stage #(
      .PRECISION (PRECISION)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .step (step),
      .din  (din),
      .acc  (acc)
    );
  end

  // ---------------------------------------------------------------------------
  // Output: (iN >>> GROWTH)[X_WIDTH-1 -: OUT_BITS], taken directly from iN.
  // The width check guarantees GROWTH + X_WIDTH - 1 <= PRECISION - 1, so the
  // arithmetic shift never has to replicate the sign into the selected bits.
  // y follows the last integrator register, so it moves only in the cycle
  // after a step, i.e. exactly when y_valid is high.
  // ---------------------------------------------------------------------------
  logic [PRECISION-1:0] i_last;
  logic [OUT_BITS-1:0]  y_msb;
  logic                 unused_i_last;

  assign i_last        = g_integ[N-1].acc;
  assign y_msb         = i_last[GROWTH + X_WIDTH - 1 -: OUT_BITS];
  assign unused_i_last = ^i_last;

  always_comb begin
    y = '0;
    y[Y_WIDTH-1 -: OUT_BITS] = y_msb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid <= 1'b0;
    end else begin
      y_valid <= step;
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// -----------------------------------------------------------------------------
// tb_cic_interpolator
//   Two instances share the stimulus: one with a 16-bit output, one with a
//   12-bit output. The reference is a direct-form model: the zero-stuffed
//   input history convolved with the CIC impulse response (a length-R*M box
//   convolved with itself N times), delayed by N steps and shifted by GROWTH.
//   Expected values are queued when a step is driven and popped on y_valid.
// -----------------------------------------------------------------------------
module tb_cic_interpolator;

  localparam int N      = 3;
  localparam int M      = 1;
  localparam int LOG2_R = 2;
  localparam int R      = 1 << LOG2_R;
  localparam int GROWTH = 4;
  localparam int HLEN   = N * (R * M - 1) + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enabled;
  logic        x_valid;
  logic [15:0] x;
  logic        x_ready;
  logic [15:0] y;
  logic        y_valid;
  logic        x_ready12;
  logic [11:0] y12;
  logic        y_valid12;

  always #5 clk = ~clk;

  cic_interpolator #(
    .N(N), .M(M), .LOG2_R(LOG2_R), .X_WIDTH(16), .Y_WIDTH(16), .PRECISION(24)
  ) dut (
    .clk(clk), .rst(rst), .enabled(enabled), .x(x), .x_valid(x_valid),
    .x_ready(x_ready), .y(y), .y_valid(y_valid)
  );

  cic_interpolator #(
    .N(N), .M(M), .LOG2_R(LOG2_R), .X_WIDTH(16), .Y_WIDTH(12), .PRECISION(24)
  ) dut12 (
    .clk(clk), .rst(rst), .enabled(enabled), .x(x), .x_valid(x_valid),
    .x_ready(x_ready12), .y(y12), .y_valid(y_valid12)
  );

  int          tests;
  int          fails;
  longint      h [HLEN];
  int          u_hist [$];
  longint      exp_q [$];
  logic [15:0] y_log [$];
  int          m_ph;
  logic [15:0] last_y;
  logic        last_ready;

  int imp_exp [20] = '{0, 0, 0, 1, 3, 6, 10, 12, 12, 10, 6, 3, 1,
                       0, 0, 0, 0, 0, 0, 0};

  function automatic void build_h();
    longint tmp [HLEN];
    for (int k = 0; k < HLEN; k++) h[k] = 0;
    h[0] = 1;
    for (int s = 0; s < N; s++) begin
      for (int k = 0; k < HLEN; k++) tmp[k] = 0;
      for (int k = 0; k < HLEN; k++)
        for (int j = 0; j < R * M; j++)
          if (k + j < HLEN) tmp[k + j] += h[k];
      h = tmp;
    end
  endfunction

  // Expected (iN >>> GROWTH) after the most recent step.
  function automatic longint model_out();
    longint acc;
    int     n;
    acc = 0;
    n   = u_hist.size() - 1;
    for (int k = 0; k < HLEN; k++) begin
      int idx;
      idx = n - N - k;
      if (idx >= 0) acc += h[k] * longint'(u_hist[idx]);
    end
    return acc >>> GROWTH;
  endfunction

  function automatic void clear_model();
    u_hist.delete();
    exp_q.delete();
    y_log.delete();
    m_ph   = 0;
    last_y = '0;
  endfunction

  // One clock cycle of stimulus with full output checking.
  task automatic cycle(input logic en, input logic xv, input logic signed [15:0] xin);
    logic             stp;
    logic             acc_step;
    logic signed [63:0] ev;
    enabled = en;
    x_valid = xv;
    x       = xin;
    #1;
    last_ready = x_ready;
    tests++;
    if (x_ready !== (en && m_ph == 0)) begin
      fails++;
      $display("FAIL x_ready: got %b expected %b (ph %0d)", x_ready, (en && m_ph == 0), m_ph);
    end
    stp      = en && (m_ph != 0 || xv);
    acc_step = stp && (m_ph == 0);
    if (stp) begin
      u_hist.push_back(acc_step ? int'(xin) : 0);
      exp_q.push_back(model_out());
      m_ph = (m_ph + 1) % R;
    end
    @(posedge clk);
    #1;
    tests++;
    if (y_valid !== stp) begin
      fails++;
      $display("FAIL y_valid: got %b expected %b", y_valid, stp);
    end
    if (y_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty: got y_valid with no expected entry");
      end else begin
        ev = exp_q.pop_front();
        tests++;
        if (y !== ev[15:0]) begin
          fails++;
          $display("FAIL y16: got %0d expected %0d", $signed(y), $signed(ev[15:0]));
        end
        tests++;
        if (y12 !== ev[15:4]) begin
          fails++;
          $display("FAIL y12: got %0d expected %0d", $signed(y12), $signed(ev[15:4]));
        end
      end
      y_log.push_back(y);
    end else begin
      tests++;
      if (y !== last_y) begin
        fails++;
        $display("FAIL y_hold: got %0d expected %0d", $signed(y), $signed(last_y));
      end
    end
    last_y = y;
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    enabled = 1'b0;
    x_valid = 1'b0;
    x       = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    enabled = 1'b1;
    x_valid = 1'b1;
    x       = 16'sd1234;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (y !== 16'd0 || y12 !== 12'd0) begin
      fails++;
      $display("FAIL reset_y: got %0d/%0d expected 0/0", $signed(y), $signed(y12));
    end
    tests++;
    if (y_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_y_valid: got %b expected 0", y_valid);
    end
    tests++;
    if (x_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ph0_ready: got %b expected 1", x_ready);
    end
    enabled = 1'b0;
    #1;
    tests++;
    if (x_ready !== 1'b0) begin
      fails++;
      $display("FAIL disabled_ready: got %b expected 0", x_ready);
    end
    rst = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
  endtask

  task automatic test_impulse();
    apply_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, (i == 0) ? 16'sd16 : 16'sd0);
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (i >= y_log.size() || y_log[i] !== 16'(imp_exp[i])) begin
        fails++;
        $display("FAIL impulse[%0d]: got %0d expected %0d", i,
                 (i < y_log.size()) ? int'($signed(y_log[i])) : -99999, imp_exp[i]);
      end
    end
  endtask

  task automatic test_dc();
    apply_reset();
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1, 16'sd1000);
    tests++;
    if (y !== 16'sd1000) begin
      fails++;
      $display("FAIL dc_pos: got %0d expected 1000", $signed(y));
    end
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1, -16'sd1000);
    tests++;
    if (y !== -16'sd1000) begin
      fails++;
      $display("FAIL dc_neg: got %0d expected -1000", $signed(y));
    end
  endtask

  task automatic test_handshake();
    int ready_count;
    apply_reset();
    ready_count = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 1'b1, 16'($signed($urandom_range(0, 16000)) - 8000));
      if (last_ready) begin
        ready_count++;
        tests++;
        if ((i % R) != 0) begin
          fails++;
          $display("FAIL ready_position: got ready at cycle %0d expected multiple of %0d", i, R);
        end
      end
    end
    tests++;
    if (ready_count != 32 / R) begin
      fails++;
      $display("FAIL ready_count: got %0d expected %0d", ready_count, 32 / R);
    end
    // Starve at phase 0: nothing may advance and y must hold.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'sd7777);
    for (int i = 0; i < 24; i++) cycle(1'b1, 1'b1, 16'($signed($urandom_range(0, 16000)) - 8000));
  endtask

  task automatic test_enable_random();
    apply_reset();
    for (int i = 0; i < 200; i++)
      cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'b1,
            16'($signed($urandom_range(0, 20000)) - 10000));
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, (i == 0) ? 16'sd16 : 16'sd0);
    rst = 1'b1;
    #1;
    tests++;
    if (y !== 16'd0 || y_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got y %0d y_valid %b expected 0/0", $signed(y), y_valid);
    end
    @(posedge clk);
    #1;
    tests++;
    if (y !== 16'd0 || y_valid !== 1'b0 || x_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_next: got y %0d y_valid %b x_ready %b expected 0/0/1",
               $signed(y), y_valid, x_ready);
    end
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, (i == 0) ? 16'sd16 : 16'sd0);
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (i >= y_log.size() || y_log[i] !== 16'(imp_exp[i])) begin
        fails++;
        $display("FAIL post_reset_impulse[%0d]: got %0d expected %0d", i,
                 (i < y_log.size()) ? int'($signed(y_log[i])) : -99999, imp_exp[i]);
      end
    end
  endtask

  task automatic test_full_scale();
    apply_reset();
    for (int i = 0; i < 96; i++)
      cycle(1'b1, 1'b1, (((i / R) % 2) == 0) ? 16'sd32767 : -16'sd32768);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    build_h();
    clear_model();
    test_reset();
    test_impulse();
    test_dc();
    test_handshake();
    test_enable_random();
    test_reset_mid();
    test_full_scale();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
